// File: rtl/character_row_sequencer_pkg.sv
// Shared definitions for the character row sequencer: cell-word field
// positions, sequencer state encoding and character cell height.
// No ports; imported by character_row_sequencer and pixel_fifo.
package character_row_sequencer_pkg;

  // Cell word layout as stored in text memory.
  localparam int CELL_INDEX_LSB     = 0;
  localparam int CELL_INDEX_MSB     = 7;
  localparam int CELL_XSIZE_BIT     = 8;
  localparam int CELL_YSIZE_BIT     = 9;
  localparam int CELL_HALFTONE_BIT  = 10;
  localparam int CELL_UNDERLINE_BIT = 11;
  localparam int CELL_INVERT_BIT    = 12;
  localparam int CELL_COLOUR_LSB    = 13;
  localparam int CELL_COLOUR_MSB    = 15;

  // Scanlines per character cell (ychar runs 0..CHARHEIGHT_RANGE-1).
  localparam int CHARHEIGHT_RANGE = 10;

  // Queued entry is {colour[2:0], pixels[7:0]}.
  localparam int PIXEL_ENTRY_WIDTH = 11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FETCH   = 2'd1,
    ST_LOAD    = 2'd2,
    ST_CAPTURE = 2'd3
  } seq_state_e;

  // An out-of-range scanline is pinned to the last row of the cell so the
  // generator never sees an index outside its glyph.
  function automatic logic [3:0] clamp_ychar(input logic [3:0] y);
    logic [3:0] y_max;
    y_max = 4'(CHARHEIGHT_RANGE - 1);
    return (y > y_max) ? y_max : y;
  endfunction

endpackage

// File: rtl/character_row_sequencer_pixel_fifo.sv
// pixel_fifo: 2-entry valid/ready FIFO with synchronous flush.
// Ports: clk, reset_n, flush, in_vld/in_rdy/in_dat (push), out_vld/out_rdy/out_dat (pop).
// out_vld and out_dat come straight from flops; push accepted on a full FIFO when popping.
module pixel_fifo
  import character_row_sequencer_pkg::*;
#(
  parameter int WIDTH = PIXEL_ENTRY_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic [WIDTH-1:0] in_dat,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [WIDTH-1:0] out_dat
);

  // head is the presented entry, tail the one behind it.
  logic             head_vld_q, head_vld_d;
  logic [WIDTH-1:0] head_dat_q, head_dat_d;
  logic             tail_vld_q, tail_vld_d;
  logic [WIDTH-1:0] tail_dat_q, tail_dat_d;
  logic             pop;
  logic             push;

  assign pop     = head_vld_q & out_rdy;
  // tail occupied means full; a pop in the same cycle frees a slot.
  assign in_rdy  = ~tail_vld_q | out_rdy;
  assign push    = in_vld & in_rdy;
  assign out_vld = head_vld_q;
  assign out_dat = head_dat_q;

  always_comb begin
    head_vld_d = head_vld_q;
    head_dat_d = head_dat_q;
    tail_vld_d = tail_vld_q;
    tail_dat_d = tail_dat_q;
    if (flush) begin
      head_vld_d = 1'b0;
      tail_vld_d = 1'b0;
    end else begin
      if (pop) begin
        head_vld_d = tail_vld_q;
        head_dat_d = tail_dat_q;
        tail_vld_d = 1'b0;
      end
      if (push) begin
        if (!head_vld_d) begin
          head_vld_d = 1'b1;
          head_dat_d = in_dat;
        end else begin
          tail_vld_d = 1'b1;
          tail_dat_d = in_dat;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      head_vld_q <= 1'b0;
      head_dat_q <= '0;
      tail_vld_q <= 1'b0;
      tail_dat_q <= '0;
    end else begin
      head_vld_q <= head_vld_d;
      head_dat_q <= head_dat_d;
      tail_vld_q <= tail_vld_d;
      tail_dat_q <= tail_dat_d;
    end
  end

endmodule

// File: rtl/character_row_sequencer.sv
// Per-scanline text row walker: fetches cell words, drives the character
// generator, queues {colour, pixels} for the serialiser; owns double-width pairing.
// Ports: line_start/row_base/ychar/lower_half (line setup), fetch_* (text memory
// req/ack), cg_* (generator), out_* (valid/ready pixel stream), line_busy/line_done.
module character_row_sequencer
  import character_row_sequencer_pkg::*;
#(
  parameter int COLUMNS         = 80,
  parameter int ADDR_WIDTH      = 12,
  parameter int CHARINDEX_WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       line_start,
  input  logic [ADDR_WIDTH-1:0]      row_base,
  input  logic [3:0]                 ychar,
  input  logic                       lower_half,
  output logic                       fetch_req,
  output logic [ADDR_WIDTH-1:0]      fetch_addr,
  input  logic                       fetch_ack,
  input  logic [15:0]                fetch_data,
  output logic [CHARINDEX_WIDTH-1:0] cg_character_index,
  output logic [3:0]                 cg_ychar,
  output logic                       cg_xsize,
  output logic                       cg_ysize,
  output logic                       cg_xpart,
  output logic                       cg_ypart,
  output logic                       cg_halftone,
  output logic                       cg_underline,
  output logic                       cg_invert,
  input  logic [7:0]                 cg_row_pixels,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [7:0]                 out_pixels,
  output logic [2:0]                 out_colour,
  output logic                       line_busy,
  output logic                       line_done
);

  localparam int COL_W = (COLUMNS > 1) ? $clog2(COLUMNS) : 1;
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLUMNS - 1);

  seq_state_e            state_q, state_d;
  logic [COL_W-1:0]      col_q, col_d;
  logic [ADDR_WIDTH-1:0] row_base_q, row_base_d;
  logic [3:0]            ychar_q, ychar_d;
  logic                  lower_half_q, lower_half_d;
  logic [15:0]           cell_q, cell_d;
  // Doubles as the pair flag: set while the right half of a wide cell is emitted.
  logic                  xpart_q, xpart_d;
  logic                  line_done_q, line_done_d;

  logic                         fifo_push_vld;
  logic                         fifo_push_rdy;
  logic                         fifo_flush;
  logic [PIXEL_ENTRY_WIDTH-1:0] fifo_push_dat;
  logic [PIXEL_ENTRY_WIDTH-1:0] fifo_out_dat;

  assign fifo_push_dat = {cell_q[CELL_COLOUR_MSB:CELL_COLOUR_LSB], cg_row_pixels};

  always_comb begin
    state_d       = state_q;
    col_d         = col_q;
    row_base_d    = row_base_q;
    ychar_d       = ychar_q;
    lower_half_d  = lower_half_q;
    cell_d        = cell_q;
    xpart_d       = xpart_q;
    line_done_d   = 1'b0;
    fifo_push_vld = 1'b0;
    fifo_flush    = 1'b0;

    if (line_start) begin
      // A new line always wins; outside IDLE this aborts the current one,
      // dropping queued bytes and any half-emitted pair.
      state_d      = ST_FETCH;
      col_d        = '0;
      row_base_d   = row_base;
      ychar_d      = clamp_ychar(ychar);
      lower_half_d = lower_half;
      xpart_d      = 1'b0;
      fifo_flush   = (state_q != ST_IDLE);
    end else begin
      unique case (state_q)
        ST_IDLE: ;
        ST_FETCH: begin
          if (fetch_ack) begin
            cell_d  = fetch_data;
            xpart_d = 1'b0;
            state_d = ST_LOAD;
          end
        end
        ST_LOAD: state_d = ST_CAPTURE;
        ST_CAPTURE: begin
          fifo_push_vld = 1'b1;
          if (fifo_push_rdy) begin
            if (col_q == LAST_COL) begin
              // A wide cell here emits only its left half.
              state_d     = ST_IDLE;
              col_d       = '0;
              xpart_d     = 1'b0;
              line_done_d = 1'b1;
            end else begin
              col_d = col_q + COL_W'(1);
              if (cell_q[CELL_XSIZE_BIT] && !xpart_q) begin
                // Right half reuses the latched cell; its own address is skipped.
                xpart_d = 1'b1;
                state_d = ST_LOAD;
              end else begin
                xpart_d = 1'b0;
                state_d = ST_FETCH;
              end
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      col_q        <= '0;
      row_base_q   <= '0;
      ychar_q      <= '0;
      lower_half_q <= 1'b0;
      cell_q       <= '0;
      xpart_q      <= 1'b0;
      line_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_base_q   <= row_base_d;
      ychar_q      <= ychar_d;
      lower_half_q <= lower_half_d;
      cell_q       <= cell_d;
      xpart_q      <= xpart_d;
      line_done_q  <= line_done_d;
    end
  end

  // Address is zero outside FETCH so the bus is quiet when idle.
  assign fetch_req  = (state_q == ST_FETCH);
  assign fetch_addr = fetch_req ? (row_base_q + ADDR_WIDTH'(col_q)) : '0;

  assign cg_character_index = CHARINDEX_WIDTH'(cell_q[CELL_INDEX_MSB:CELL_INDEX_LSB]);
  assign cg_ychar           = ychar_q;
  assign cg_xsize           = cell_q[CELL_XSIZE_BIT];
  assign cg_ysize           = cell_q[CELL_YSIZE_BIT];
  assign cg_xpart           = xpart_q;
  assign cg_ypart           = lower_half_q & cell_q[CELL_YSIZE_BIT];
  assign cg_halftone        = cell_q[CELL_HALFTONE_BIT];
  assign cg_underline       = cell_q[CELL_UNDERLINE_BIT];
  assign cg_invert          = cell_q[CELL_INVERT_BIT];

  assign line_busy = (state_q != ST_IDLE);
  assign line_done = line_done_q;

  pixel_fifo #(
    .WIDTH(PIXEL_ENTRY_WIDTH)
  ) u_pixel_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .flush   (fifo_flush),
    .in_vld  (fifo_push_vld),
    .in_rdy  (fifo_push_rdy),
    .in_dat  (fifo_push_dat),
    .out_vld (out_valid),
    .out_rdy (out_ready),
    .out_dat (fifo_out_dat)
  );

  assign out_colour = fifo_out_dat[10:8];
  assign out_pixels = fifo_out_dat[7:0];

endmodule

// File: tb/tb_character_row_sequencer.sv
// Scoreboard bench: a line-level reference model queues expected addresses and
// pixel bytes; responder, generator model and output monitor run as separate processes.
module tb_character_row_sequencer;

  localparam int COLS = 4;
  localparam int AW   = 12;
  localparam int CW   = 8;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          line_start;
  logic [AW-1:0] row_base;
  logic [3:0]    ychar;
  logic          lower_half;
  logic          fetch_req;
  logic [AW-1:0] fetch_addr;
  logic          fetch_ack;
  logic [15:0]   fetch_data;
  logic [CW-1:0] cg_character_index;
  logic [3:0]    cg_ychar;
  logic          cg_xsize, cg_ysize, cg_xpart, cg_ypart;
  logic          cg_halftone, cg_underline, cg_invert;
  logic [7:0]    cg_row_pixels;
  logic          out_valid;
  logic          out_ready;
  logic [7:0]    out_pixels;
  logic [2:0]    out_colour;
  logic          line_busy;
  logic          line_done;

  always #5 clk = ~clk;

  character_row_sequencer #(
    .COLUMNS(COLS), .ADDR_WIDTH(AW), .CHARINDEX_WIDTH(CW)
  ) dut (
    .clk(clk), .reset_n(reset_n), .line_start(line_start), .row_base(row_base),
    .ychar(ychar), .lower_half(lower_half), .fetch_req(fetch_req),
    .fetch_addr(fetch_addr), .fetch_ack(fetch_ack), .fetch_data(fetch_data),
    .cg_character_index(cg_character_index), .cg_ychar(cg_ychar),
    .cg_xsize(cg_xsize), .cg_ysize(cg_ysize), .cg_xpart(cg_xpart),
    .cg_ypart(cg_ypart), .cg_halftone(cg_halftone), .cg_underline(cg_underline),
    .cg_invert(cg_invert), .cg_row_pixels(cg_row_pixels), .out_valid(out_valid),
    .out_ready(out_ready), .out_pixels(out_pixels), .out_colour(out_colour),
    .line_busy(line_busy), .line_done(line_done)
  );

  int checks   = 0;
  int failures = 0;

  logic [15:0]   mem [0:4095];
  logic [10:0]   exp_q [$];
  logic [AW-1:0] addr_q [$];
  int ready_mode = 0;   // 0: always ready, 1: random, 2: never
  int ack_slow   = 0;   // ack with probability 1/(ack_slow+1) per cycle
  int ack_count  = 0;
  int done_count = 0;
  int pop_count  = 0;

  // Generator stand-in: every control input perturbs the returned row.
  function automatic logic [7:0] gen_f(input logic [7:0] idx, input logic [3:0] y,
                                       input logic xs, input logic ys, input logic xp,
                                       input logic yp, input logic ht, input logic ul,
                                       input logic iv);
    logic [31:0] v;
    logic [31:0] h;
    v = {13'd0, idx, y, xs, ys, xp, yp, ht, ul, iv};
    h = v * 32'h9E37_79B1;
    return h[20:13] ^ {xp, yp, ht, ul, iv, xs, ys, 1'b0};
  endfunction

  // Reference model of one full scanline.
  task automatic build_line(input logic [AW-1:0] base, input logic [3:0] y, input logic lower);
    int c;
    logic [15:0]   w;
    logic [AW-1:0] a;
    c = 0;
    while (c < COLS) begin
      a = base + AW'(c);
      w = mem[a];
      addr_q.push_back(a);
      exp_q.push_back({w[15:13], gen_f(w[7:0], y, w[8], w[9], 1'b0, lower & w[9],
                                       w[10], w[11], w[12])});
      if (w[8] && c < COLS - 1) begin
        exp_q.push_back({w[15:13], gen_f(w[7:0], y, w[8], w[9], 1'b1, lower & w[9],
                                         w[10], w[11], w[12])});
        c += 2;
      end else begin
        c += 1;
      end
    end
  endtask

  // Generator with one cycle of latency.
  initial begin : generator_model
    logic [7:0] nxt;
    cg_row_pixels = 8'h00;
    forever begin
      @(negedge clk);
      nxt = gen_f(cg_character_index, cg_ychar, cg_xsize, cg_ysize, cg_xpart, cg_ypart,
                  cg_halftone, cg_underline, cg_invert);
      @(posedge clk);
      #1 cg_row_pixels = nxt;
    end
  end

  // Text memory responder.
  initial begin : responder
    logic [AW-1:0] exp_a;
    fetch_ack  = 1'b0;
    fetch_data = 16'h0000;
    forever begin
      @(negedge clk);
      if (fetch_req && !line_start && $urandom_range(0, ack_slow) == 0) begin
        fetch_ack  = 1'b1;
        fetch_data = mem[fetch_addr];
        ack_count++;
        checks++;
        if (addr_q.size() == 0) begin
          failures++;
          $display("FAIL fetch_addr: got %h, expected no fetch", fetch_addr);
        end else begin
          exp_a = addr_q.pop_front();
          if (fetch_addr !== exp_a) begin
            failures++;
            $display("FAIL fetch_addr: got %h, expected %h", fetch_addr, exp_a);
          end
        end
      end else begin
        fetch_ack  = 1'b0;
        fetch_data = 16'($urandom);
      end
    end
  end

  // Output monitor and consumer.
  initial begin : monitor
    logic [10:0] e;
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
      @(negedge clk);
      if (line_done) done_count++;
      if (out_valid && out_ready) begin
        pop_count++;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL out_byte: got %h/%h, expected no byte", out_colour, out_pixels);
        end else begin
          e = exp_q.pop_front();
          if ({out_colour, out_pixels} !== e) begin
            failures++;
            $display("FAIL out_byte: got colour %h pixels %h, expected colour %h pixels %h",
                     out_colour, out_pixels, e[10:8], e[7:0]);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", name, got, expv);
    end
  endtask

  task automatic start_line(input logic [AW-1:0] base, input logic [3:0] y, input logic lower);
    build_line(base, y, lower);
    row_base   = base;
    ychar      = y;
    lower_half = lower;
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || line_busy) && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (n >= budget) begin
      failures++;
      $display("FAIL %s_timeout: got %0d bytes still pending, expected 0", name, exp_q.size());
      exp_q.delete();
      addr_q.delete();
    end
    repeat (3) tick();
  endtask

  task automatic single_width(input logic [AW-1:0] base);
    for (int i = 0; i < COLS; i++) mem[base + AW'(i)][8] = 1'b0;
  endtask

  initial begin : main
    int d0, a0, p0;
    logic [AW-1:0] b;
    reset_n    = 1'b0;
    line_start = 1'b0;
    row_base   = '0;
    ychar      = 4'd0;
    lower_half = 1'b0;
    for (int i = 0; i < 4096; i++) begin
      mem[i] = 16'($urandom);
      if ($urandom_range(0, 2) != 0) mem[i][8] = 1'b0;
    end

    // Reset state.
    tick();
    tick();
    chk("reset_fetch_req", 32'(fetch_req), 0);
    chk("reset_fetch_addr", 32'(fetch_addr), 0);
    chk("reset_out", 32'({out_valid, out_pixels, out_colour}), 0);
    chk("reset_line", 32'({line_busy, line_done}), 0);
    chk("reset_cg", 32'({cg_character_index, cg_ychar, cg_xsize, cg_ysize, cg_xpart,
                         cg_ypart, cg_halftone, cg_underline, cg_invert}), 0);
    reset_n = 1'b1;
    tick();

    // Plain line, immediate acks, always ready.
    single_width(12'h100);
    ready_mode = 0;
    ack_slow   = 0;
    d0 = done_count;
    p0 = pop_count;
    start_line(12'h100, 4'd3, 1'b0);
    chk("first_fetch_req", 32'(fetch_req), 1);
    chk("first_fetch_addr", 32'(fetch_addr), 32'h100);
    wait_done("plain", 200);
    chk("plain_line_done", 32'(done_count - d0), 1);
    chk("plain_bytes", 32'(pop_count - p0), 4);

    // Double-width cell at column 1 skips address 0x101+1.
    single_width(12'h100);
    mem[12'h101] = 16'h0141;
    d0 = done_count;
    a0 = ack_count;
    start_line(12'h100, 4'd5, 1'b0);
    wait_done("double", 200);
    chk("double_fetches", 32'(ack_count - a0), 3);
    chk("double_line_done", 32'(done_count - d0), 1);

    // Double-width cell in the last column: left half only.
    single_width(12'h180);
    mem[12'h183][8] = 1'b1;
    p0 = pop_count;
    start_line(12'h180, 4'd9, 1'b1);
    wait_done("lastwide", 200);
    chk("lastwide_bytes", 32'(pop_count - p0), 4);

    // Backpressure: two bytes queue, FSM stalls without fetching.
    single_width(12'h200);
    ready_mode = 2;
    d0 = done_count;
    a0 = ack_count;
    p0 = pop_count;
    start_line(12'h200, 4'd1, 1'b0);
    repeat (30) tick();
    chk("stall_fetches", 32'(ack_count - a0), 3);
    chk("stall_out_valid", 32'(out_valid), 1);
    chk("stall_fetch_req", 32'(fetch_req), 0);
    ready_mode = 0;
    wait_done("stall", 200);
    chk("stall_bytes", 32'(pop_count - p0), 4);
    chk("stall_line_done", 32'(done_count - d0), 1);

    // Abort mid-line at column 2.
    single_width(12'h300);
    single_width(12'h350);
    ready_mode = 2;
    d0 = done_count;
    start_line(12'h300, 4'd2, 1'b0);
    repeat (30) tick();
    chk("abort_pre_valid", 32'(out_valid), 1);
    exp_q.delete();
    addr_q.delete();
    start_line(12'h350, 4'd4, 1'b1);
    chk("abort_flushed", 32'(out_valid), 0);
    chk("abort_fetch_req", 32'(fetch_req), 1);
    chk("abort_fetch_addr", 32'(fetch_addr), 32'h350);
    ready_mode = 0;
    wait_done("abort", 200);
    chk("abort_line_done", 32'(done_count - d0), 1);

    // ypart: lower half with ysize set and clear.
    single_width(12'h400);
    mem[12'h400][9] = 1'b1;
    mem[12'h401][9] = 1'b0;
    mem[12'h402][9] = 1'b1;
    mem[12'h403][9] = 1'b0;
    start_line(12'h400, 4'd7, 1'b1);
    wait_done("ypart", 200);

    // Randomized lines, including an address wrap.
    for (int k = 0; k < 12; k++) begin
      b = (k == 0) ? 12'hFFE : AW'($urandom);
      ready_mode = 1;
      ack_slow   = $urandom_range(0, 3);
      d0 = done_count;
      start_line(b, 4'($urandom_range(0, 9)), 1'($urandom_range(0, 1)));
      wait_done("random", 400);
      chk("random_line_done", 32'(done_count - d0), 1);
    end

    chk("leftover_bytes", 32'(exp_q.size()), 0);
    chk("leftover_fetches", 32'(addr_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
